cla_add_sched: RTL and testbench
================================

Name: cla_add_sched

Overview:
Round-robin scheduler that shares a single CLA_8bit slice between two requesters for WIDTH-bit add/subtract. Each operation is split into WIDTH/8 byte slices, executed one slice per cycle, with the carry registered between slices. Area-saving alternative to a full-width adder for non-critical address/partial-product accumulation in the RV32IM multiplier/ALU support logic.

Parameters:
WIDTH, 32, operand/result width; must be a multiple of 8, minimum 8
NSLICE, WIDTH/8, derived slice count (localparam, not overridable)

Ports:
clk  in  1  clock, rising edge
rst  in  1  synchronous active-high reset
req0_valid  in  1  requester 0 has an operation
req0_ready  out  1  requester 0 accepted this cycle
req0_a  in  WIDTH  operand A
req0_b  in  WIDTH  operand B
req0_sub  in  1  1 = A-B, 0 = A+B
req1_valid/req1_ready/req1_a/req1_b/req1_sub  same as requester 0
rsp_valid  out  1  result available
rsp_ready  in  1  consumer takes result
rsp_id  out  1  requester that issued the result
rsp_sum  out  WIDTH  result
rsp_cout  out  1  final carry out (for sub: 1 = no borrow)

Behaviour:
- One clock, clk; reset rst is synchronous, active-high.
- States: IDLE, RUN, DONE.
- Reset: state IDLE, rr pointer = 0, slice counter 0, carry 0, rsp_valid 0, rsp_id 0, rsp_sum 0, rsp_cout 0, both req_ready 0.
- IDLE: req_ready is combinational. Only the winning requester sees ready=1, and only in IDLE. Winner: if exactly one valid, that one; if both valid, the requester named by the rr pointer.
- Transfer on valid&ready. Latch A, B^{WIDTH{sub}}, carry=sub, id. Then go to RUN with counter 0.
- Requesters hold valid and operands until ready. A non-granted request must not be dropped.
- RUN: CLA_8bit gets A[8k+7:8k], B'[8k+7:8k], carry. Sum byte k is written to the result register. Carry register takes cout. k increments.
- After k = NSLICE-1, go to DONE.
- DONE: rsp_valid=1. rsp_sum, rsp_cout and rsp_id are stable. On rsp_ready: go to IDLE and set rr pointer to the other requester (~rsp_id).
- In DONE, rsp_ready low holds all outputs. No new grant happens while not in IDLE.
- Latency: accept in cycle T, slices in T+1..T+NSLICE, rsp_valid first high in T+NSLICE+1. Minimum issue interval is NSLICE+2 cycles.
- rsp_ready is ignored outside DONE.
- rst during RUN/DONE: operation is abandoned. No response is produced, rsp_valid goes 0 the next cycle, pointer returns to 0.
- Unsigned wrap-around. Sum is modulo 2^WIDTH, and carry out is reported only via rsp_cout.

Optional Feature:
CLA_SCHED_OVF_EN
- Defined: adds output rsp_ovf (1 bit), the signed overflow of the full operation. It is computed in the last slice as the carry into the MSB XOR the carry out of the MSB. Reset 0, held in DONE with the other outputs.
- Undefined: port and logic are absent. All other behaviour is identical.

Decomposition:
- Package cla_sched_pkg: state enum (IDLE, RUN, DONE), SLICE_W = 8 constant, requester-id typedef.
- Datapath: instantiate the existing CLA_8bit (which uses CLA_4bit). No new arithmetic sub-module.
- Natural new sub-module: rr_arb2, a 2-input round-robin grant with pointer update on completion. Everything else stays in cla_add_sched.

Test Plan:
- Basic add, timing: req0 A=0x000000FF, B=0x00000001, sub=0, accepted cycle T -> rsp_valid at T+5, sum=0x00000100, cout=0, id=0.
- Full carry ripple: req1 A=0xFFFFFFFF, B=0x00000001 -> sum=0x00000000, cout=1, id=1. With CLA_SCHED_OVF_EN: ovf=0.
- Subtract: req0 A=5, B=7, sub=1 -> sum=0xFFFFFFFE, cout=0. A=7, B=5 -> sum=2, cout=1.
- Contention: both valid right after reset -> req0 granted first, req1 waits with ready=0. Then req1 is served. Next simultaneous pair -> req1 first (pointer = 1 after req0 completion, 0 after req1 completion, continuing to alternate).
- Backpressure and reset: hold rsp_ready=0 for 3 cycles in DONE -> outputs stable, no req_ready asserted. Then assert rst mid-RUN of a new op -> no rsp_valid, IDLE next cycle, all outputs 0.
- Overflow (CLA_SCHED_OVF_EN): 0x7FFFFFFF+1 -> sum=0x80000000, ovf=1, cout=0.

Source files
------------

// File: rtl/cla_sched_pkg.sv
// Shared types and constants for the byte-serial CLA add/subtract scheduler.
package cla_sched_pkg;

    // Controller phases: waiting for a request, stepping slices, holding the result
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    // Width of the shared adder slice
    localparam int SLICE_W = 8;

    // Identifies which of the two requesters owns an operation
    typedef logic req_id_t;

endpackage

// File: rtl/CLA_4bit.sv
// 4-bit carry-lookahead adder block: generate/propagate with full lookahead carries.
module CLA_4bit (
    input  logic [3:0] a,
    input  logic [3:0] b,
    input  logic       cin,
    output logic [3:0] sum,
    output logic       cout
);

    logic [3:0] p;
    logic [3:0] g;
    logic [4:1] c;

    // Lookahead carries are flattened so every carry depends only on p, g and cin
    always_comb begin
        p    = a ^ b;
        g    = a & b;
        c[1] = g[0] | (p[0] & cin);
        c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & cin);
        c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & cin);
        c[4] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0])
             | (p[3] & p[2] & p[1] & p[0] & cin);
        sum  = p ^ {c[3], c[2], c[1], cin};
        cout = c[4];
    end

endmodule

// File: rtl/CLA_8bit.sv
// 8-bit adder built from two 4-bit lookahead blocks with a carry between nibbles.
module CLA_8bit (
    input  logic [7:0] a,
    input  logic [7:0] b,
    input  logic       cin,
    output logic [7:0] sum,
    output logic       cout
);

    logic c_mid;

    CLA_4bit u_lo (
        .a    (a[3:0]),
        .b    (b[3:0]),
        .cin  (cin),
        .sum  (sum[3:0]),
        .cout (c_mid)
    );

    CLA_4bit u_hi (
        .a    (a[7:4]),
        .b    (b[7:4]),
        .cin  (c_mid),
        .sum  (sum[7:4]),
        .cout (cout)
    );

endmodule

// File: rtl/cla_add_sched_rr_arb2.sv
// Two-way round-robin arbiter; the pointer moves to the other requester when a
// response is consumed, so the requester that just finished loses the next tie.
module rr_arb2
    import cla_sched_pkg::*;
(
    input  logic    clk,
    input  logic    rst,
    input  logic    en,
    input  logic    req0,
    input  logic    req1,
    input  logic    done,
    input  req_id_t done_id,
    output logic    gnt0,
    output logic    gnt1,
    output req_id_t gnt_id
);

    req_id_t ptr;

    // Pointer favours the requester that did not own the last completed operation
    always_ff @(posedge clk) begin
        if (rst) begin
            ptr <= 1'b0;
        end else if (done) begin
            ptr <= ~done_id;
        end
    end

    // A lone requester always wins; the pointer only breaks ties
    always_comb begin
        gnt_id = ptr;
        if (req0 && !req1) begin
            gnt_id = 1'b0;
        end else if (req1 && !req0) begin
            gnt_id = 1'b1;
        end
        gnt0 = en && req0 && (gnt_id == 1'b0);
        gnt1 = en && req1 && (gnt_id == 1'b1);
    end

endmodule

// File: rtl/cla_add_sched.sv
// Shares one CLA_8bit between two requesters, computing WIDTH-bit add/sub one
// byte per cycle with the carry registered between bytes.
// Optional signed-overflow output is enabled by defining CLA_SCHED_OVF_EN.
module cla_add_sched
    import cla_sched_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req0_valid,
    output logic             req0_ready,
    input  logic [WIDTH-1:0] req0_a,
    input  logic [WIDTH-1:0] req0_b,
    input  logic             req0_sub,
    input  logic             req1_valid,
    output logic             req1_ready,
    input  logic [WIDTH-1:0] req1_a,
    input  logic [WIDTH-1:0] req1_b,
    input  logic             req1_sub,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic             rsp_id,
    output logic [WIDTH-1:0] rsp_sum,
    output logic             rsp_cout
`ifdef CLA_SCHED_OVF_EN
    ,
    output logic             rsp_ovf
`endif
);

    localparam int NSLICE = WIDTH / SLICE_W;
    localparam int CNT_W  = (NSLICE > 1) ? $clog2(NSLICE) : 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(NSLICE - 1);

    state_t             state;
    state_t             state_nxt;
    logic [CNT_W-1:0]   cnt;
    logic               carry;
    logic [WIDTH-1:0]   a_reg;
    logic [WIDTH-1:0]   b_reg;
    logic [WIDTH-1:0]   sum_reg;
    req_id_t            id_reg;

    logic               gnt0;
    logic               gnt1;
    req_id_t            gnt_id;
    logic               accept;
    logic               take;

    logic [WIDTH-1:0]   sel_a;
    logic [WIDTH-1:0]   sel_b;
    logic               sel_sub;

    int                 base;
    logic [SLICE_W-1:0] a_slice;
    logic [SLICE_W-1:0] b_slice;
    logic [SLICE_W-1:0] slice_sum;
    logic               slice_cout;

    // Grants are only offered while idle and never during reset
    rr_arb2 u_arb (
        .clk     (clk),
        .rst     (rst),
        .en      ((state == IDLE) && !rst),
        .req0    (req0_valid),
        .req1    (req1_valid),
        .done    (take),
        .done_id (id_reg),
        .gnt0    (gnt0),
        .gnt1    (gnt1),
        .gnt_id  (gnt_id)
    );

    assign req0_ready = gnt0;
    assign req1_ready = gnt1;
    assign accept     = gnt0 || gnt1;
    assign take       = (state == DONE) && rsp_ready;

    // State register for the IDLE/RUN/DONE controller
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic; rsp_valid is simply "in DONE"
    always_comb begin
        state_nxt = state;
        rsp_valid = 1'b0;
        case (state)
            IDLE: begin
                if (accept) begin
                    state_nxt = RUN;
                end
            end
            RUN: begin
                if (cnt == LAST) begin
                    state_nxt = DONE;
                end
            end
            DONE: begin
                rsp_valid = 1'b1;
                if (rsp_ready) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Operand select for the winner and byte select for the current slice
    always_comb begin
        sel_a   = gnt1 ? req1_a   : req0_a;
        sel_b   = gnt1 ? req1_b   : req0_b;
        sel_sub = gnt1 ? req1_sub : req0_sub;
        base    = int'(cnt) * SLICE_W;
        a_slice = a_reg[base +: SLICE_W];
        b_slice = b_reg[base +: SLICE_W];
    end

    CLA_8bit u_cla (
        .a    (a_slice),
        .b    (b_slice),
        .cin  (carry),
        .sum  (slice_sum),
        .cout (slice_cout)
    );

    // Subtraction is A + ~B + 1, so B is inverted on capture and carry seeded with sub
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt     <= '0;
            carry   <= 1'b0;
            a_reg   <= '0;
            b_reg   <= '0;
            sum_reg <= '0;
            id_reg  <= 1'b0;
        end else if (accept) begin
            cnt     <= '0;
            carry   <= sel_sub;
            a_reg   <= sel_a;
            b_reg   <= sel_b ^ {WIDTH{sel_sub}};
            id_reg  <= gnt_id;
        end else if (state == RUN) begin
            sum_reg[base +: SLICE_W] <= slice_sum;
            carry                    <= slice_cout;
            cnt                      <= cnt + 1'b1;
        end
    end

    assign rsp_sum  = sum_reg;
    assign rsp_cout = carry;
    assign rsp_id   = id_reg;

`ifdef CLA_SCHED_OVF_EN
    logic msb_cin;
    logic ovf_reg;

    assign msb_cin = a_slice[SLICE_W-1] ^ b_slice[SLICE_W-1] ^ slice_sum[SLICE_W-1];

    // Signed overflow is carry into the MSB xor carry out, taken on the top slice only
    always_ff @(posedge clk) begin
        if (rst) begin
            ovf_reg <= 1'b0;
        end else if (accept) begin
            ovf_reg <= 1'b0;
        end else if ((state == RUN) && (cnt == LAST)) begin
            ovf_reg <= msb_cin ^ slice_cout;
        end
    end

    assign rsp_ovf = ovf_reg;
`endif

endmodule

// File: tb/tb_cla_add_sched.sv
// Directed bench for cla_add_sched (WIDTH = 32): timing, arithmetic, arbitration,
// backpressure and mid-operation reset. Overflow checks compile in with CLA_SCHED_OVF_EN.
module tb_cla_add_sched;

    localparam int WIDTH = 32;

    logic             clk = 1'b0;
    logic             rst;
    logic             req0_valid, req0_ready, req0_sub;
    logic [WIDTH-1:0] req0_a, req0_b;
    logic             req1_valid, req1_ready, req1_sub;
    logic [WIDTH-1:0] req1_a, req1_b;
    logic             rsp_valid, rsp_ready, rsp_id, rsp_cout;
    logic [WIDTH-1:0] rsp_sum;
`ifdef CLA_SCHED_OVF_EN
    logic             rsp_ovf;
`endif

    int vectors     = 0;
    int miscompares = 0;

    cla_add_sched #(.WIDTH(WIDTH)) dut (
        .clk        (clk),
        .rst        (rst),
        .req0_valid (req0_valid),
        .req0_ready (req0_ready),
        .req0_a     (req0_a),
        .req0_b     (req0_b),
        .req0_sub   (req0_sub),
        .req1_valid (req1_valid),
        .req1_ready (req1_ready),
        .req1_a     (req1_a),
        .req1_b     (req1_b),
        .req1_sub   (req1_sub),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_id     (rsp_id),
        .rsp_sum    (rsp_sum),
        .rsp_cout   (rsp_cout)
`ifdef CLA_SCHED_OVF_EN
        ,
        .rsp_ovf    (rsp_ovf)
`endif
    );

    always #5 clk = ~clk;

    // Synchronous reset for two edges, released 1 time unit after an edge
    task automatic do_reset();
        rst = 1'b1;
        req0_valid = 1'b0; req1_valid = 1'b0; rsp_ready = 1'b0;
        req0_a = '0; req0_b = '0; req0_sub = 1'b0;
        req1_a = '0; req1_b = '0; req1_sub = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
    endtask

    // Present an operation on one requester until it is accepted (bounded)
    task automatic issue(input bit who, input logic [31:0] a, input logic [31:0] b,
                         input logic sub, output bit timeout);
        bit rdy;
        if (who) begin
            req1_a = a; req1_b = b; req1_sub = sub; req1_valid = 1'b1;
        end else begin
            req0_a = a; req0_b = b; req0_sub = sub; req0_valid = 1'b1;
        end
        timeout = 1'b1;
        for (int n = 0; n < 30; n++) begin
            #1 rdy = who ? req1_ready : req0_ready;
            @(posedge clk);
            #1;
            if (rdy) begin
                timeout = 1'b0;
                break;
            end
        end
        if (who) req1_valid = 1'b0;
        else     req0_valid = 1'b0;
    endtask

    // Wait for rsp_valid (bounded); lat is the cycle index relative to the accept cycle
    task automatic wait_rsp(input bit release_rsp, output logic [31:0] sum, output logic cout,
                            output logic id, output logic ovf, output int lat, output bit timeout);
        lat = 1;
        while (!rsp_valid && lat < 30) begin
            @(posedge clk);
            #1 lat++;
        end
        timeout = !rsp_valid;
        sum  = rsp_sum;
        cout = rsp_cout;
        id   = rsp_id;
`ifdef CLA_SCHED_OVF_EN
        ovf  = rsp_ovf;
`else
        ovf  = 1'b0;
`endif
        if (release_rsp && !timeout) begin
            rsp_ready = 1'b1;
            @(posedge clk);
            #1 rsp_ready = 1'b0;
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        rsp_ready = 1'b0;
        req0_valid = 1'b1; req1_valid = 1'b1;
        req0_a = 32'h1; req0_b = 32'h2; req0_sub = 1'b0;
        req1_a = 32'h3; req1_b = 32'h4; req1_sub = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        vectors++;
        if ({rsp_valid, rsp_id, rsp_cout, rsp_sum} !== 35'd0) begin
            miscompares++;
            $display("[TB] FAIL reset_outputs got v=%b id=%b c=%b s=%h want all 0",
                     rsp_valid, rsp_id, rsp_cout, rsp_sum);
        end
        vectors++;
        if ({req0_ready, req1_ready} !== 2'b00) begin
            miscompares++;
            $display("[TB] FAIL reset_ready got %b%b want 00", req0_ready, req1_ready);
        end
`ifdef CLA_SCHED_OVF_EN
        vectors++;
        if (rsp_ovf !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL reset_ovf got %b want 0", rsp_ovf);
        end
`endif
        req0_valid = 1'b0; req1_valid = 1'b0;
        rst = 1'b0;
    endtask

    task automatic test_basic_add();
        logic [31:0] s; logic c, id, o; int lat; bit to;
        issue(1'b0, 32'h0000_00FF, 32'h0000_0001, 1'b0, to);
        wait_rsp(1'b1, s, c, id, o, lat, to);
        vectors++;
        if (to) begin miscompares++; $display("[TB] FAIL basic_timeout got no rsp want rsp"); end
        vectors++;
        if (lat !== 5) begin miscompares++; $display("[TB] FAIL basic_latency got %0d want 5", lat); end
        vectors++;
        if (s !== 32'h0000_0100) begin miscompares++; $display("[TB] FAIL basic_sum got %h want 00000100", s); end
        vectors++;
        if ({c, id} !== 2'b00) begin miscompares++; $display("[TB] FAIL basic_cout_id got %b%b want 00", c, id); end
    endtask

    task automatic test_carry_ripple();
        logic [31:0] s; logic c, id, o; int lat; bit to;
        issue(1'b1, 32'hFFFF_FFFF, 32'h0000_0001, 1'b0, to);
        wait_rsp(1'b1, s, c, id, o, lat, to);
        vectors++;
        if (s !== 32'h0000_0000) begin miscompares++; $display("[TB] FAIL ripple_sum got %h want 00000000", s); end
        vectors++;
        if ({c, id} !== 2'b11) begin miscompares++; $display("[TB] FAIL ripple_cout_id got %b%b want 11", c, id); end
`ifdef CLA_SCHED_OVF_EN
        vectors++;
        if (o !== 1'b0) begin miscompares++; $display("[TB] FAIL ripple_ovf got %b want 0", o); end
`endif
    endtask

    task automatic test_subtract();
        logic [31:0] s; logic c, id, o; int lat; bit to;
        issue(1'b0, 32'd5, 32'd7, 1'b1, to);
        wait_rsp(1'b1, s, c, id, o, lat, to);
        vectors++;
        if ({s, c} !== {32'hFFFF_FFFE, 1'b0}) begin
            miscompares++; $display("[TB] FAIL sub_5_7 got %h c=%b want fffffffe c=0", s, c);
        end
        issue(1'b0, 32'd7, 32'd5, 1'b1, to);
        wait_rsp(1'b1, s, c, id, o, lat, to);
        vectors++;
        if ({s, c} !== {32'h0000_0002, 1'b1}) begin
            miscompares++; $display("[TB] FAIL sub_7_5 got %h c=%b want 00000002 c=1", s, c);
        end
    endtask

`ifdef CLA_SCHED_OVF_EN
    task automatic test_overflow();
        logic [31:0] s; logic c, id, o; int lat; bit to;
        issue(1'b0, 32'h7FFF_FFFF, 32'h0000_0001, 1'b0, to);
        wait_rsp(1'b1, s, c, id, o, lat, to);
        vectors++;
        if ({s, o, c} !== {32'h8000_0000, 1'b1, 1'b0}) begin
            miscompares++; $display("[TB] FAIL ovf_add got %h o=%b c=%b want 80000000 o=1 c=0", s, o, c);
        end
    endtask
`endif

    task automatic test_contention();
        logic [31:0] s; logic c, id, o; int lat; bit to;
        do_reset();
        req0_a = 32'h10; req0_b = 32'h20; req0_sub = 1'b0; req0_valid = 1'b1;
        req1_a = 32'h1234_5678; req1_b = 32'h1111_1111; req1_sub = 1'b0; req1_valid = 1'b1;
        #1;
        vectors++;
        if ({req0_ready, req1_ready} !== 2'b10) begin
            miscompares++; $display("[TB] FAIL cont_first_grant got %b%b want 10", req0_ready, req1_ready);
        end
        @(posedge clk);
        #1 req0_a = 32'h100; req0_b = 32'h1; req0_sub = 1'b1;
        #1;
        vectors++;
        if ({req0_ready, req1_ready} !== 2'b00) begin
            miscompares++; $display("[TB] FAIL cont_run_ready got %b%b want 00", req0_ready, req1_ready);
        end
        wait_rsp(1'b1, s, c, id, o, lat, to);
        vectors++;
        if ({id, s} !== {1'b0, 32'h0000_0030}) begin
            miscompares++; $display("[TB] FAIL cont_rsp0 got id=%b %h want id=0 00000030", id, s);
        end
        #1;
        vectors++;
        if ({req0_ready, req1_ready} !== 2'b01) begin
            miscompares++; $display("[TB] FAIL cont_second_grant got %b%b want 01", req0_ready, req1_ready);
        end
        @(posedge clk);
        #1 req1_a = 32'd3; req1_b = 32'd4; req1_sub = 1'b0;
        wait_rsp(1'b1, s, c, id, o, lat, to);
        vectors++;
        if ({id, s} !== {1'b1, 32'h2345_6789}) begin
            miscompares++; $display("[TB] FAIL cont_rsp1 got id=%b %h want id=1 23456789", id, s);
        end
        #1;
        vectors++;
        if ({req0_ready, req1_ready} !== 2'b10) begin
            miscompares++; $display("[TB] FAIL cont_third_grant got %b%b want 10", req0_ready, req1_ready);
        end
        @(posedge clk);
        #1 req0_valid = 1'b0;
        wait_rsp(1'b1, s, c, id, o, lat, to);
        vectors++;
        if ({id, s, c} !== {1'b0, 32'h0000_00FF, 1'b1}) begin
            miscompares++; $display("[TB] FAIL cont_rsp2 got id=%b %h c=%b want id=0 000000ff c=1", id, s, c);
        end
        #1;
        vectors++;
        if ({req0_ready, req1_ready} !== 2'b01) begin
            miscompares++; $display("[TB] FAIL cont_fourth_grant got %b%b want 01", req0_ready, req1_ready);
        end
        @(posedge clk);
        #1 req1_valid = 1'b0;
        wait_rsp(1'b1, s, c, id, o, lat, to);
        vectors++;
        if ({id, s} !== {1'b1, 32'h0000_0007}) begin
            miscompares++; $display("[TB] FAIL cont_rsp3 got id=%b %h want id=1 00000007", id, s);
        end
    endtask

    task automatic test_backpressure_reset();
        logic [31:0] s; logic c, id, o; int lat; bit to; bit seen;
        issue(1'b0, 32'h0000_00AA, 32'h0000_0055, 1'b0, to);
        wait_rsp(1'b0, s, c, id, o, lat, to);
        req0_a = 32'h9; req0_b = 32'h9; req0_sub = 1'b0; req0_valid = 1'b1;
        req1_a = 32'h1; req1_b = 32'h2; req1_sub = 1'b0; req1_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #2;
            vectors++;
            if ({rsp_valid, rsp_sum, rsp_cout, rsp_id, req0_ready, req1_ready}
                    !== {1'b1, 32'h0000_00FF, 1'b0, 1'b0, 1'b0, 1'b0}) begin
                miscompares++;
                $display("[TB] FAIL bp_hold cycle %0d got v=%b s=%h c=%b id=%b rdy=%b%b want v=1 s=000000ff c=0 id=0 rdy=00",
                         i, rsp_valid, rsp_sum, rsp_cout, rsp_id, req0_ready, req1_ready);
            end
        end
        rsp_ready = 1'b1;
        @(posedge clk);
        #1 rsp_ready = 1'b0;
        #1;
        vectors++;
        if ({req0_ready, req1_ready} !== 2'b01) begin
            miscompares++; $display("[TB] FAIL bp_next_grant got %b%b want 01", req0_ready, req1_ready);
        end
        @(posedge clk);
        #1 req0_valid = 1'b0; req1_valid = 1'b0;
        @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk);
        #1;
        vectors++;
        if ({rsp_valid, rsp_sum, rsp_cout, rsp_id, req0_ready, req1_ready} !== 37'd0) begin
            miscompares++;
            $display("[TB] FAIL rst_mid_run got v=%b s=%h c=%b id=%b rdy=%b%b want all 0",
                     rsp_valid, rsp_sum, rsp_cout, rsp_id, req0_ready, req1_ready);
        end
        rst = 1'b0;
        seen = 1'b0;
        repeat (8) begin
            @(posedge clk);
            #1 if (rsp_valid) seen = 1'b1;
        end
        vectors++;
        if (seen !== 1'b0) begin
            miscompares++; $display("[TB] FAIL rst_no_rsp got rsp_valid=1 want 0");
        end
        req0_valid = 1'b1; req1_valid = 1'b1;
        #1;
        vectors++;
        if ({req0_ready, req1_ready} !== 2'b10) begin
            miscompares++; $display("[TB] FAIL rst_ptr got %b%b want 10", req0_ready, req1_ready);
        end
        req0_valid = 1'b0; req1_valid = 1'b0;
        @(posedge clk);
        #1;
    endtask

    initial begin
        test_reset();
        test_basic_add();
        test_carry_ripple();
        test_subtract();
`ifdef CLA_SCHED_OVF_EN
        test_overflow();
`endif
        test_contention();
        test_backpressure_reset();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
